// File: rtl/mod_pipe_pkg.sv
// Shared definitions for the modulation pipe: default geometry and the
// serializer state encoding. The segment stages import this package too.
package mod_pipe_pkg;

  localparam int WORD_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int SYM_CYCLES_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Counter width that still works when only one value is needed.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_sym_timer.sv
// Symbol-period timer. Down-counts from SYM_CYCLES-1; tick marks the last
// cycle of a symbol, tick_next predicts whether the following cycle will be.
module mod_sym_timer
  import mod_pipe_pkg::*;
#(
  parameter int SYM_CYCLES = SYM_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick,
  output logic tick_next
);

  localparam int          SYM_W = cnt_width(SYM_CYCLES);
  localparam logic [SYM_W-1:0] LOAD = SYM_W'(SYM_CYCLES - 1);

  logic [SYM_W-1:0] cnt;

  // Reload at the start of every symbol, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= LOAD;
    end else if (restart) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - SYM_W'(1);
    end
  end

  assign tick      = (cnt == '0);
  // A restart makes the next cycle the last one only for single-cycle symbols.
  assign tick_next = restart ? (SYM_CYCLES == 1) : (cnt == SYM_W'(1));

endmodule

// File: rtl/mod_bit_serializer.sv
// Word-to-bit serializer feeding the segment stages. One-word holding buffer
// in front of an LSB-first shifter; each bit is held for SYM_CYCLES clocks.
//
//   state | meaning
//   IDLE  | shifter empty, outputs quiet, waiting for the hold buffer to fill
//   SHIFT | emitting a word, one bit per symbol period
module mod_bit_serializer
  import mod_pipe_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SYM_CYCLES = SYM_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] input_bit,
  output logic [DATA_W-1:0] zero,
  output logic              bit_strobe,
  output logic              word_start,
  output logic              word_done,
  output logic              bit_active
);

  localparam int               BIT_W    = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  ser_state_t        state;
  logic              rdy_en;
  logic              hold_valid;
  logic [WORD_W-1:0] hold_data;
  logic [WORD_W-1:0] shifter;
  logic [BIT_W-1:0]  bit_cnt;
  logic              out_bit;

  logic              sym_tick;
  logic              sym_tick_next;
  logic              accept;
  logic              end_word;
  logic              load_now;
  logic              advance;
  logic              restart;
  logic              shift_nxt;
  logic              done_nxt;
  logic [BIT_W-1:0]  bit_cnt_nxt;

  mod_sym_timer #(.SYM_CYCLES(SYM_CYCLES)) u_sym_timer (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .tick      (sym_tick),
    .tick_next (sym_tick_next)
  );

  // rdy_en keeps in_ready low until the first edge after reset release.
  assign in_ready  = rdy_en && !hold_valid && !flush;
  assign accept    = in_valid && in_ready;
  assign input_bit = DATA_W'(out_bit);
  assign zero      = '0;

  // Next-state decode; word_done is predicted one cycle early so it can be registered.
  always_comb begin
    end_word    = (state == SHIFT) && sym_tick && (bit_cnt == LAST_BIT);
    advance     = (state == SHIFT) && sym_tick && (bit_cnt != LAST_BIT);
    load_now    = hold_valid && ((state == IDLE) || end_word);
    restart     = flush || load_now || advance;
    shift_nxt   = load_now || ((state == SHIFT) && !end_word);
    bit_cnt_nxt = bit_cnt;
    if (load_now) begin
      bit_cnt_nxt = '0;
    end else if (advance) begin
      bit_cnt_nxt = bit_cnt + BIT_W'(1);
    end
    done_nxt = shift_nxt && (bit_cnt_nxt == LAST_BIT) && sym_tick_next;
  end

  // Hold buffer, shifter, bit counter, state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rdy_en     <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      shifter    <= '0;
      bit_cnt    <= '0;
      out_bit    <= 1'b0;
      bit_strobe <= 1'b0;
      word_start <= 1'b0;
      word_done  <= 1'b0;
      bit_active <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (flush) begin
        state      <= IDLE;
        hold_valid <= 1'b0;
        hold_data  <= '0;
        shifter    <= '0;
        bit_cnt    <= '0;
        out_bit    <= 1'b0;
        bit_strobe <= 1'b0;
        word_start <= 1'b0;
        word_done  <= 1'b0;
        bit_active <= 1'b0;
      end else begin
        if (accept) begin
          hold_valid <= 1'b1;
          hold_data  <= in_data;
        end else if (load_now) begin
          hold_valid <= 1'b0;
        end
        state      <= shift_nxt ? SHIFT : IDLE;
        bit_cnt    <= bit_cnt_nxt;
        bit_strobe <= load_now || advance;
        word_start <= load_now;
        word_done  <= done_nxt;
        bit_active <= shift_nxt;
        if (load_now) begin
          shifter <= hold_data >> 1;
          out_bit <= hold_data[0];
        end else if (advance) begin
          shifter <= shifter >> 1;
          out_bit <= shifter[0];
        end else if (!shift_nxt) begin
          out_bit <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_bit_serializer.sv
// Self-checking bench: two serializers (SYM_CYCLES 8 and 1) checked every
// cycle against a position-based reference model, plus literal checks.
module tb_mod_bit_serializer;

  localparam int W = 32;

  typedef struct packed {
    logic [31:0] cur;
    logic [31:0] pend;
    logic        pending;
    logic        active;
    logic        started;
    logic [15:0] p;
  } model_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        flush_a, valid_a, ready_a, strobe_a, wstart_a, wdone_a, active_a;
  logic [31:0] data_a, ibit_a, zero_a;
  logic        flush_b, valid_b, ready_b, strobe_b, wstart_b, wdone_b, active_b;
  logic [31:0] data_b, ibit_b, zero_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int starts_a[$];
  int dones_a[$];
  int rdy_start_a[$];
  int rdy_done_a[$];

  model_t ma, mb;

  mod_bit_serializer #(.WORD_W(W), .DATA_W(32), .SYM_CYCLES(8)) dut_a (
    .clk(clk), .reset(reset), .flush(flush_a), .in_data(data_a), .in_valid(valid_a),
    .in_ready(ready_a), .input_bit(ibit_a), .zero(zero_a), .bit_strobe(strobe_a),
    .word_start(wstart_a), .word_done(wdone_a), .bit_active(active_a));

  mod_bit_serializer #(.WORD_W(W), .DATA_W(32), .SYM_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .flush(flush_b), .in_data(data_b), .in_valid(valid_b),
    .in_ready(ready_b), .input_bit(ibit_b), .zero(zero_b), .bit_strobe(strobe_b),
    .word_start(wstart_b), .word_done(wdone_b), .bit_active(active_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: p is the cycle position inside the current word (0 .. W*s-1).
  function automatic model_t mstep(input model_t m, input int s, input logic fl,
                                   input logic vld, input logic [31:0] d);
    model_t n;
    logic   acc;
    n = m;
    n.started = 1'b1;
    if (fl) begin
      n.pending = 1'b0;
      n.active  = 1'b0;
      n.p       = '0;
      return n;
    end
    acc = vld && m.started && !m.pending;
    if (m.active && (int'(m.p) < W * s - 1)) begin
      n.p = m.p + 16'd1;
    end else if (m.pending) begin
      n.cur     = m.pend;
      n.p       = '0;
      n.active  = 1'b1;
      n.pending = 1'b0;
    end else begin
      n.active = 1'b0;
      n.p      = '0;
    end
    if (acc) begin
      n.pending = 1'b1;
      n.pend    = d;
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= mstep(ma, 8, flush_a, valid_a, data_a);
      mb <= mstep(mb, 1, flush_b, valid_b, data_b);
    end
  end

  task automatic check_dut(input string nm, input model_t m, input int s, input logic fl,
                           input logic rdy, input logic [31:0] ib, input logic [31:0] zr,
                           input logic st, input logic ws, input logic wd, input logic ac);
    logic eb;
    eb = m.active ? m.cur[int'(m.p) / s] : 1'b0;
    chk({nm, ".in_ready"},   32'(rdy), 32'(m.started && !m.pending && !fl));
    chk({nm, ".input_bit"},  ib, 32'(eb));
    chk({nm, ".zero"},       zr, 32'h0);
    chk({nm, ".bit_strobe"}, 32'(st), 32'(m.active && (int'(m.p) % s == 0)));
    chk({nm, ".word_start"}, 32'(ws), 32'(m.active && (m.p == 16'd0)));
    chk({nm, ".word_done"},  32'(wd), 32'(m.active && (int'(m.p) == W * s - 1)));
    chk({nm, ".bit_active"}, 32'(ac), 32'(m.active));
  endtask

  always @(negedge clk) begin
    cyc++;
    if (wstart_a) begin
      starts_a.push_back(cyc);
      rdy_start_a.push_back(int'(ready_a));
    end
    if (wdone_a) begin
      dones_a.push_back(cyc);
      rdy_done_a.push_back(int'(ready_a));
    end
    check_dut("a", ma, 8, flush_a, ready_a, ibit_a, zero_a, strobe_a, wstart_a, wdone_a, active_a);
    check_dut("b", mb, 1, flush_b, ready_b, ibit_b, zero_b, strobe_b, wstart_b, wdone_b, active_b);
  end

  task automatic offer(input bit sel, input logic [31:0] w);
    int n = 0;
    @(posedge clk); #1;
    if (sel) begin valid_b = 1'b1; data_b = w; end
    else     begin valid_a = 1'b1; data_a = w; end
    forever begin
      @(negedge clk);
      if (sel ? ready_b : ready_a) break;
      n++;
      if (n > 600) begin
        chk("offer_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    if (sel) valid_b = 1'b0;
    else     valid_a = 1'b0;
  endtask

  task automatic wait_start(input bit sel, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? wstart_b : wstart_a) && n < 50);
    chk(nm, 32'(sel ? wstart_b : wstart_a), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, done_at, extra, cnt, pct;
    reset = 1'b1;
    flush_a = 0; valid_a = 0; data_a = '0;
    flush_b = 0; valid_b = 0; data_b = '0;
    #2 reset = 1'b0;
    #1;
    chk("reset.in_ready", 32'(ready_a), 32'd0);
    chk("reset.input_bit", ibit_a, 32'd0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("release.in_ready", 32'(ready_a), 32'd1);

    // 1: single word 5, 8-cycle symbols
    offer(0, 32'h0000_0005);
    wait_start(0, "t1.start");
    done_at = 0; extra = 0;
    for (int c = 1; c <= 257; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1)  chk("t1.bit0",     ibit_a, 32'd1);
      if (c == 8)  chk("t1.bit0_end", ibit_a, 32'd1);
      if (c == 9)  chk("t1.bit1",     ibit_a, 32'd0);
      if (c == 17) chk("t1.bit2",     ibit_a, 32'd1);
      if (c == 25) chk("t1.bit3",     ibit_a, 32'd0);
      if (wdone_a && done_at == 0) done_at = c;
      if (wstart_a && c > 1) extra++;
      if (c == 257) begin
        chk("t1.idle_active", 32'(active_a), 32'd0);
        chk("t1.idle_bit", ibit_a, 32'd0);
      end
    end
    chk("t1.done_cycle", 32'(done_at), 32'd256);
    chk("t1.restarts", 32'(extra), 32'd0);

    // 3: SYM_CYCLES=1, all ones
    offer(1, 32'hFFFF_FFFF);
    wait_start(1, "t3.start");
    cnt = 0;
    for (int c = 0; c < 32; c++) begin
      if (c > 0) @(negedge clk);
      if (ibit_b == 32'd1 && strobe_b && active_b) cnt++;
    end
    chk("t3.ones_strobed", 32'(cnt), 32'd32);
    @(negedge clk);
    chk("t3.after_active", 32'(active_b), 32'd0);
    chk("t3.after_bit", ibit_b, 32'd0);

    // 2: back-to-back words, seamless
    s0 = starts_a.size();
    d0 = dones_a.size();
    offer(0, 32'hA5A5_A5A5);
    offer(0, 32'h0F0F_0F0F);
    repeat (600) @(negedge clk);
    chk("t2.starts", 32'(starts_a.size() - s0), 32'd2);
    chk("t2.dones", 32'(dones_a.size() - d0), 32'd2);
    if (starts_a.size() >= s0 + 2 && dones_a.size() >= d0 + 1) begin
      chk("t2.len", 32'(dones_a[d0] - starts_a[s0]), 32'd255);
      chk("t2.gap", 32'(starts_a[s0 + 1] - dones_a[d0]), 32'd1);
      chk("t2.rdy_at_done", 32'(rdy_done_a[d0]), 32'd0);
      chk("t2.rdy_after_load", 32'(rdy_start_a[s0 + 1]), 32'd1);
    end

    // 4: flush at bit 10 with hold full
    offer(0, 32'h1234_5678);
    offer(0, 32'hCAFE_F00D);
    s0 = starts_a.size();
    if (s0 > 0) begin
      done_at = starts_a[s0 - 1] + 83;
      for (int n = 0; n < 200 && cyc < done_at; n++) @(negedge clk);
    end
    @(posedge clk); #1;
    flush_a = 1'b1; valid_a = 1'b1; data_a = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t4.ready_in_flush", 32'(ready_a), 32'd0);
    d0 = dones_a.size();
    s0 = starts_a.size();
    @(posedge clk); #1;
    flush_a = 1'b0; valid_a = 1'b0;
    @(negedge clk);
    chk("t4.active", 32'(active_a), 32'd0);
    chk("t4.hold_empty", 32'(ready_a), 32'd1);
    repeat (300) @(negedge clk);
    chk("t4.no_done", 32'(dones_a.size()), 32'(d0));
    chk("t4.no_start", 32'(starts_a.size()), 32'(s0));

    // 5: async reset mid-symbol
    offer(0, 32'h8000_0001);
    wait_start(0, "t5.start");
    repeat (20) @(negedge clk);
    d0 = dones_a.size();
    @(posedge clk); #3 reset = 1'b0;
    #1;
    chk("t5.bit", ibit_a, 32'd0);
    chk("t5.active", 32'(active_a), 32'd0);
    chk("t5.strobe", 32'(strobe_a), 32'd0);
    chk("t5.ready", 32'(ready_a), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("t5.ready_after", 32'(ready_a), 32'd1);
    offer(0, 32'h0000_0006);
    wait_start(0, "t5.restart");
    chk("t5.new_bit0", ibit_a, 32'd0);
    repeat (8) @(negedge clk);
    chk("t5.new_bit1", ibit_a, 32'd1);
    repeat (260) @(negedge clk);
    chk("t5.one_done", 32'(dones_a.size() - d0), 32'd1);

    // 6: random traffic on both serializers, model checks every cycle
    fork
      begin
        for (int i = 0; i < 5000; i++) begin
          @(posedge clk); #1;
          pct = ((i / 700) % 2 == 0) ? 60 : 2;
          valid_a = ($urandom_range(0, 99) < pct);
          data_a  = $urandom;
          flush_a = ($urandom_range(0, 399) == 0);
        end
        @(posedge clk); #1;
        valid_a = 1'b0; flush_a = 1'b0;
      end
      begin
        for (int i = 0; i < 1500; i++) begin
          @(posedge clk); #1;
          valid_b = ($urandom_range(0, 99) < 30);
          data_b  = $urandom;
          flush_b = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1;
        valid_b = 1'b0; flush_b = 1'b0;
      end
    join
    repeat (600) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
